vote_collector: RTL and testbench
=================================

// Module: vote_collector
// PURPOSE
//   Front end of the three-judge voting unit. Synchronises and debounces one host "start" button and
//   three judge buttons, then runs a timed voting round. At round end it presents the latched votes
//   vote_a/vote_b/vote_c to the downstream 2-of-3 majority combiner (inputs A/B/C), plus status flags.
// PARAMETERS
//   DEBOUNCE_CYCLES  20   consecutive stable clocks before a debounced level changes (board: 1_000_000)
//   WINDOW_CYCLES    100  length of a voting round in clocks, >= 2
//   Counter widths are $clog2(param+1); no other derived parameters.
// PORTS
//   clk          in   1  single system clock, all logic rising-edge
//   rst          in   1  asynchronous, active-high reset
//   start_btn    in   1  raw host button, asynchronous, active-high
//   judge_btn    in   3  raw judge buttons [0]=A [1]=B [2]=C, asynchronous, active-high
//   vote_a       out  1  latched vote of judge A; valid only while votes_valid=1, else 0
//   vote_b       out  1  latched vote of judge B; same rule
//   vote_c       out  1  latched vote of judge C; same rule
//   votes_valid  out  1  high while in HOLD (votes stable for the majority combiner)
//   round_done   out  1  one-clock pulse on the first HOLD cycle
//   timeout      out  1  in HOLD: 1 = round ended by window expiry, 0 = all three voted; 0 elsewhere
//   busy         out  1  high while in COLLECT
//   voted        out  3  live per-judge "has voted" bits (LEDs); cleared on round start
// BEHAVIOUR
//   Reset: rst=1 forces IDLE and clears every register immediately; all outputs 0, including sync/debounce state.
//   Input path, per button (4 identical lanes): 2-FF synchroniser (reset 0) -> debounce counter ->
//     registered rising-edge detect producing a one-clock press pulse.
//   Debounce: if synced level != debounced level, counter increments, else counter clears; when the
//     counter reaches DEBOUNCE_CYCLES the debounced level flips and the counter clears.
//     Pulses shorter than DEBOUNCE_CYCLES clocks never change the level.
//   Latency: raw rising edge first sampled at edge N -> press pulse high in cycle N+DEBOUNCE_CYCLES+3, exact.
//   Releases produce no pulse; a held button produces exactly one pulse.
//   FSM (IDLE, COLLECT, HOLD):
//   IDLE: start press -> COLLECT; voted<=0; window counter <= WINDOW_CYCLES-1. Judge presses ignored.
//   COLLECT: busy=1; counter decrements each clock; judge press i sets voted[i] (sticky; repeats ignored).
//     Start presses ignored. Exit to HOLD in the clock after either:
//     (a) voted, including a press this cycle, == 3'b111 -> timeout<=0, or
//     (b) counter == 0 -> timeout<=1.
//     If (a) and (b) happen in the same cycle, (a) wins: that vote counts, timeout=0.
//     Round length is therefore at most WINDOW_CYCLES clocks.
//   HOLD: vote_x = voted[x], votes_valid=1, round_done=1 in first cycle only. Judge presses ignored.
//     Start press -> COLLECT with voted cleared, counter reloaded, votes_valid/timeout drop to 0
//     in the same transition.
//   No illegal-state lockup: any unencoded state decodes to IDLE.
// TESTING
//   T1 rst pulsed mid-COLLECT after A voted -> all outputs 0 immediately, voted=000; judge press alone
//      then does nothing; a start press is required to begin a new round.
//   T2 10-clock glitches on judge_btn[1] (< DEBOUNCE_CYCLES) -> no vote; clean A,C presses, window expires
//      -> vote_a=1 vote_b=0 vote_c=1, timeout=1, round_done one clock, majority y=1.
//   T3 start, then A,B,C pressed at ~20-clock spacing -> HOLD before expiry, votes 111, timeout=0;
//      press-to-voted latency exactly DEBOUNCE_CYCLES+3.
//   T4 only B presses, B held 300 clocks and pressed twice -> voted=010 (single count), timeout=1,
//      majority y=0.
//   T5 third vote's press pulse aligned with counter==0 -> votes 111, timeout=0.
//   T6 start pressed during COLLECT -> ignored, round continues; start in HOLD -> COLLECT,
//      votes_valid=0, voted=000, full WINDOW_CYCLES window reloaded.

Source files
------------

// File: rtl/vote_collector_if.sv
// Button inputs and vote/status outputs of the three-judge vote collector.
// Latency: none, plain wiring bundle.
// Backpressure: none, level and pulse signals only.
// Ports: start_btn, judge_btn[2:0] driven by the board/host side;
//        vote_a/b/c, votes_valid, round_done, timeout, busy, voted[2:0] driven by the collector.
interface vote_collector_if;
  logic       start_btn;
  logic [2:0] judge_btn;
  logic       vote_a;
  logic       vote_b;
  logic       vote_c;
  logic       votes_valid;
  logic       round_done;
  logic       timeout;
  logic       busy;
  logic [2:0] voted;

  modport master (
    output start_btn, judge_btn,
    input  vote_a, vote_b, vote_c, votes_valid, round_done, timeout, busy, voted
  );

  modport slave (
    input  start_btn, judge_btn,
    output vote_a, vote_b, vote_c, votes_valid, round_done, timeout, busy, voted
  );
endinterface

// File: rtl/vote_collector.sv
// Synchronise/debounce start + three judge buttons and run a timed voting round.
// Latency: raw edge sampled at edge N -> press pulse in cycle N+DEBOUNCE_CYCLES+3.
// Backpressure: none; votes held stable in HOLD until the next start press.
// Ports: clk, rst (async, active-high); bus (slave modport): raw buttons in,
//        latched votes, votes_valid, round_done, timeout, busy and live voted LEDs out.
module vote_collector #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int WINDOW_CYCLES   = 100
) (
  input logic              clk,
  input logic              rst,
  vote_collector_if.slave  bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [WW-1:0] WIN_LOAD = WW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Lane 0 is the start button, lanes 3:1 are judges C,B,A.
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    db_lvl;
  logic [3:0]    db_prev;
  logic [3:0]    press;
  logic [DW-1:0] db_cnt [4];

  assign raw = {bus.judge_btn, bus.start_btn};

  // The level flips on the clock after the counter has reached DB_MAX, and only
  // if the synced input still disagrees, so a pulse must survive DB_MAX+1 samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      db_lvl  <= '0;
      db_prev <= '0;
      press   <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      db_prev <= db_lvl;
      press   <= db_lvl & ~db_prev;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != db_lvl[i]) begin
          if (db_cnt[i] == DB_MAX) begin
            db_lvl[i] <= ~db_lvl[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  logic          start_press;
  logic [2:0]    judge_press;
  state_t        state, state_n;
  logic [2:0]    voted_q, voted_n, vote_mix;
  logic [WW-1:0] win_cnt, win_n;
  logic          timeout_q, timeout_n;
  logic          done_q, done_n;

  assign start_press = press[0];
  assign judge_press = press[3:1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      voted_q   <= '0;
      win_cnt   <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      voted_q   <= voted_n;
      win_cnt   <= win_n;
      timeout_q <= timeout_n;
      done_q    <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    voted_n   = voted_q;
    win_n     = win_cnt;
    timeout_n = timeout_q;
    done_n    = 1'b0;
    vote_mix  = voted_q | judge_press;
    case (state)
      IDLE: begin
        if (start_press) begin
          state_n   = COLLECT;
          voted_n   = '0;
          win_n     = WIN_LOAD;
          timeout_n = 1'b0;
        end
      end
      COLLECT: begin
        voted_n = vote_mix;
        // A completing vote takes priority over window expiry in the same cycle.
        if (vote_mix == 3'b111) begin
          state_n   = HOLD;
          timeout_n = 1'b0;
          done_n    = 1'b1;
        end else if (win_cnt == '0) begin
          state_n   = HOLD;
          timeout_n = 1'b1;
          done_n    = 1'b1;
        end else begin
          win_n = win_cnt - WW'(1);
        end
      end
      HOLD: begin
        if (start_press) begin
          state_n   = COLLECT;
          voted_n   = '0;
          win_n     = WIN_LOAD;
          timeout_n = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        voted_n   = '0;
        win_n     = '0;
        timeout_n = 1'b0;
      end
    endcase
  end

  assign bus.busy        = (state == COLLECT);
  assign bus.votes_valid = (state == HOLD);
  assign bus.vote_a      = (state == HOLD) & voted_q[0];
  assign bus.vote_b      = (state == HOLD) & voted_q[1];
  assign bus.vote_c      = (state == HOLD) & voted_q[2];
  assign bus.timeout     = (state == HOLD) & timeout_q;
  assign bus.round_done  = done_q;
  assign bus.voted       = voted_q;
endmodule

// File: tb/tb_vote_collector.sv
// Directed bench for vote_collector with DEBOUNCE_CYCLES=20, WINDOW_CYCLES=100.
// Timing reference: an input driven during cycle c is first sampled at edge c+1,
// so its press pulse is high in cycle c+24 and a judge's voted bit shows in c+25.
// A start driven in cycle s gives COLLECT in cycles s+25..s+124 and HOLD from s+125 on expiry.
module tb_vote_collector;
  localparam int D = 20;
  localparam int W = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  vote_collector_if vif ();

  vote_collector #(.DEBOUNCE_CYCLES(D), .WINDOW_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Park at the falling edge inside cycle c (after rising edge c).
  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  task automatic do_reset();
    vif.start_btn = 1'b0;
    vif.judge_btn = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    wait_cyc(cyc + 2);
    rst = 1'b0;
    wait_cyc(cyc + 2);
  endtask

  task automatic test_reset();
    vif.start_btn = 1'b0;
    vif.judge_btn = 3'b000;
    wait_cyc(3);
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", vif.busy); end
    checks++; if (vif.votes_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", vif.votes_valid); end
    checks++; if (vif.voted !== 3'b000) begin errors++; $display("FAIL rst_voted got %b exp 000", vif.voted); end
    checks++; if ({vif.vote_a, vif.vote_b, vif.vote_c, vif.round_done, vif.timeout} !== 5'b0)
      begin errors++; $display("FAIL rst_outs got %b exp 00000", {vif.vote_a, vif.vote_b, vif.vote_c, vif.round_done, vif.timeout}); end
    rst = 1'b0;
    wait_cyc(cyc + 2);
  endtask

  // T1: reset mid-COLLECT, then a lone judge press must not start anything.
  task automatic test_reset_mid_round();
    int s0, r0;
    do_reset();
    s0 = cyc;
    vif.start_btn = 1'b1;
    wait_cyc(s0 + 5);  vif.judge_btn[0] = 1'b1;
    wait_cyc(s0 + 30); vif.start_btn = 1'b0;
    wait_cyc(s0 + 35); vif.judge_btn[0] = 1'b0;
    checks++; if (vif.busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b exp 1", vif.busy); end
    checks++; if (vif.voted !== 3'b001) begin errors++; $display("FAIL t1_voted got %b exp 001", vif.voted); end
    wait_cyc(s0 + 60);
    rst = 1'b1;
    #1;
    checks++; if (vif.busy !== 1'b0) begin errors++; $display("FAIL t1_async_busy got %b exp 0", vif.busy); end
    checks++; if (vif.voted !== 3'b000) begin errors++; $display("FAIL t1_async_voted got %b exp 000", vif.voted); end
    wait_cyc(cyc + 2);
    rst = 1'b0;
    r0 = cyc;
    vif.judge_btn[1] = 1'b1;
    wait_cyc(r0 + 30); vif.judge_btn[1] = 1'b0;
    wait_cyc(r0 + 60);
    checks++; if ({vif.busy, vif.votes_valid, vif.voted} !== 5'b0)
      begin errors++; $display("FAIL t1_judge_idle got %b exp 00000", {vif.busy, vif.votes_valid, vif.voted}); end
    r0 = cyc;
    vif.start_btn = 1'b1;
    wait_cyc(r0 + 30); vif.start_btn = 1'b0;
    wait_cyc(r0 + 40);
    checks++; if ({vif.busy, vif.voted} !== 4'b1000)
      begin errors++; $display("FAIL t1_restart got %b exp 1000", {vif.busy, vif.voted}); end
  endtask

  // T2: short glitches on B are filtered; A and C vote; window expires.
  task automatic test_glitch_timeout();
    int s0;
    do_reset();
    s0 = cyc;
    vif.start_btn = 1'b1;
    wait_cyc(s0 + 30); vif.start_btn = 1'b0; vif.judge_btn[1] = 1'b1;
    wait_cyc(s0 + 40); vif.judge_btn[1] = 1'b0; vif.judge_btn[0] = 1'b1;
    wait_cyc(s0 + 50); vif.judge_btn[1] = 1'b1;
    wait_cyc(s0 + 60); vif.judge_btn[1] = 1'b0; vif.judge_btn[2] = 1'b1;
    wait_cyc(s0 + 70); vif.judge_btn[0] = 1'b0;
    wait_cyc(s0 + 90); vif.judge_btn[2] = 1'b0;
    wait_cyc(s0 + 124);
    checks++; if ({vif.busy, vif.votes_valid, vif.voted} !== 5'b10101)
      begin errors++; $display("FAIL t2_last_collect got %b exp 10101", {vif.busy, vif.votes_valid, vif.voted}); end
    wait_cyc(s0 + 125);
    checks++; if ({vif.vote_a, vif.vote_b, vif.vote_c} !== 3'b101)
      begin errors++; $display("FAIL t2_votes got %b exp 101", {vif.vote_a, vif.vote_b, vif.vote_c}); end
    checks++; if ({vif.votes_valid, vif.round_done, vif.timeout, vif.busy} !== 4'b1110)
      begin errors++; $display("FAIL t2_flags got %b exp 1110", {vif.votes_valid, vif.round_done, vif.timeout, vif.busy}); end
    checks++; if (maj(vif.vote_a, vif.vote_b, vif.vote_c) !== 1'b1)
      begin errors++; $display("FAIL t2_majority got %b exp 1", maj(vif.vote_a, vif.vote_b, vif.vote_c)); end
    wait_cyc(s0 + 126);
    checks++; if ({vif.votes_valid, vif.round_done} !== 2'b10)
      begin errors++; $display("FAIL t2_done_pulse got %b exp 10", {vif.votes_valid, vif.round_done}); end
  endtask

  // T3: all three vote early; exact press-to-voted latency on A.
  task automatic test_all_vote();
    int s0;
    do_reset();
    s0 = cyc;
    vif.start_btn = 1'b1;
    wait_cyc(s0 + 5);  vif.judge_btn[0] = 1'b1;
    wait_cyc(s0 + 25); vif.judge_btn[1] = 1'b1;
    // A first sampled at edge s0+6: pulse in cycle s0+6+D+3, registered into voted one edge later.
    wait_cyc(s0 + 6 + D + 3);
    checks++; if (vif.voted[0] !== 1'b0) begin errors++; $display("FAIL t3_lat_early got %b exp 0", vif.voted[0]); end
    wait_cyc(s0 + 6 + D + 4);
    checks++; if (vif.voted[0] !== 1'b1) begin errors++; $display("FAIL t3_lat_exact got %b exp 1", vif.voted[0]); end
    wait_cyc(s0 + 30); vif.start_btn = 1'b0;
    wait_cyc(s0 + 35); vif.judge_btn[0] = 1'b0;
    wait_cyc(s0 + 45); vif.judge_btn[2] = 1'b1;
    wait_cyc(s0 + 55); vif.judge_btn[1] = 1'b0;
    wait_cyc(s0 + 69);
    checks++; if ({vif.busy, vif.voted} !== 4'b1011)
      begin errors++; $display("FAIL t3_pre_hold got %b exp 1011", {vif.busy, vif.voted}); end
    wait_cyc(s0 + 70);
    checks++; if ({vif.vote_a, vif.vote_b, vif.vote_c} !== 3'b111)
      begin errors++; $display("FAIL t3_votes got %b exp 111", {vif.vote_a, vif.vote_b, vif.vote_c}); end
    checks++; if ({vif.votes_valid, vif.round_done, vif.timeout, vif.busy} !== 4'b1100)
      begin errors++; $display("FAIL t3_flags got %b exp 1100", {vif.votes_valid, vif.round_done, vif.timeout, vif.busy}); end
    wait_cyc(s0 + 75); vif.judge_btn[2] = 1'b0;
  endtask

  // T4: B alone, held 300 clocks then pressed again in HOLD.
  task automatic test_single_held();
    int s0;
    do_reset();
    s0 = cyc;
    vif.start_btn = 1'b1;
    wait_cyc(s0 + 5);  vif.judge_btn[1] = 1'b1;
    wait_cyc(s0 + 30); vif.start_btn = 1'b0;
    wait_cyc(s0 + 124);
    checks++; if ({vif.busy, vif.voted} !== 4'b1010)
      begin errors++; $display("FAIL t4_collect got %b exp 1010", {vif.busy, vif.voted}); end
    wait_cyc(s0 + 125);
    checks++; if ({vif.vote_a, vif.vote_b, vif.vote_c, vif.timeout, vif.round_done} !== 5'b01011)
      begin errors++; $display("FAIL t4_hold got %b exp 01011", {vif.vote_a, vif.vote_b, vif.vote_c, vif.timeout, vif.round_done}); end
    checks++; if (maj(vif.vote_a, vif.vote_b, vif.vote_c) !== 1'b0)
      begin errors++; $display("FAIL t4_majority got %b exp 0", maj(vif.vote_a, vif.vote_b, vif.vote_c)); end
    wait_cyc(s0 + 305); vif.judge_btn[1] = 1'b0;
    wait_cyc(s0 + 340); vif.judge_btn[1] = 1'b1;
    wait_cyc(s0 + 370); vif.judge_btn[1] = 1'b0;
    wait_cyc(s0 + 400);
    checks++; if ({vif.votes_valid, vif.round_done, vif.timeout, vif.voted} !== 6'b101010)
      begin errors++; $display("FAIL t4_repress got %b exp 101010", {vif.votes_valid, vif.round_done, vif.timeout, vif.voted}); end
  endtask

  // T5: third vote's pulse lands in the counter==0 cycle; the vote wins.
  task automatic test_vote_at_expiry();
    int s0;
    do_reset();
    s0 = cyc;
    vif.start_btn = 1'b1;
    wait_cyc(s0 + 10); vif.judge_btn[0] = 1'b1;
    wait_cyc(s0 + 30); vif.start_btn = 1'b0;
    wait_cyc(s0 + 40); vif.judge_btn[0] = 1'b0; vif.judge_btn[1] = 1'b1;
    wait_cyc(s0 + 70); vif.judge_btn[1] = 1'b0;
    wait_cyc(s0 + 100); vif.judge_btn[2] = 1'b1;  // pulse in cycle s0+124 = last COLLECT cycle
    wait_cyc(s0 + 124);
    checks++; if ({vif.busy, vif.voted} !== 4'b1011)
      begin errors++; $display("FAIL t5_last_collect got %b exp 1011", {vif.busy, vif.voted}); end
    wait_cyc(s0 + 125);
    checks++; if ({vif.vote_a, vif.vote_b, vif.vote_c, vif.votes_valid, vif.timeout} !== 5'b11110)
      begin errors++; $display("FAIL t5_hold got %b exp 11110", {vif.vote_a, vif.vote_b, vif.vote_c, vif.votes_valid, vif.timeout}); end
    wait_cyc(s0 + 130); vif.judge_btn[2] = 1'b0;
  endtask

  // T6: start ignored in COLLECT; start in HOLD begins a fresh full round.
  task automatic test_start_restart();
    int s0, s1;
    do_reset();
    s0 = cyc;
    vif.start_btn = 1'b1;
    wait_cyc(s0 + 5);  vif.judge_btn[0] = 1'b1;
    wait_cyc(s0 + 30); vif.start_btn = 1'b0;
    wait_cyc(s0 + 35); vif.judge_btn[0] = 1'b0;
    wait_cyc(s0 + 60); vif.start_btn = 1'b1;
    wait_cyc(s0 + 90); vif.start_btn = 1'b0;
    wait_cyc(s0 + 124);
    checks++; if ({vif.busy, vif.voted} !== 4'b1001)
      begin errors++; $display("FAIL t6_ignored got %b exp 1001", {vif.busy, vif.voted}); end
    wait_cyc(s0 + 125);
    checks++; if ({vif.votes_valid, vif.timeout, vif.vote_a} !== 3'b111)
      begin errors++; $display("FAIL t6_hold got %b exp 111", {vif.votes_valid, vif.timeout, vif.vote_a}); end
    s1 = s0 + 130;
    wait_cyc(s1); vif.start_btn = 1'b1;
    wait_cyc(s1 + 24);
    checks++; if ({vif.votes_valid, vif.busy} !== 2'b10)
      begin errors++; $display("FAIL t6_still_hold got %b exp 10", {vif.votes_valid, vif.busy}); end
    wait_cyc(s1 + 25);
    checks++; if ({vif.busy, vif.votes_valid, vif.timeout, vif.vote_a, vif.voted} !== 7'b1000000)
      begin errors++; $display("FAIL t6_restart got %b exp 1000000", {vif.busy, vif.votes_valid, vif.timeout, vif.vote_a, vif.voted}); end
    wait_cyc(s1 + 30); vif.start_btn = 1'b0;
    wait_cyc(s1 + 124);
    checks++; if (vif.busy !== 1'b1) begin errors++; $display("FAIL t6_full_window got %b exp 1", vif.busy); end
    wait_cyc(s1 + 125);
    checks++; if ({vif.busy, vif.votes_valid, vif.timeout, vif.round_done} !== 4'b0111)
      begin errors++; $display("FAIL t6_end got %b exp 0111", {vif.busy, vif.votes_valid, vif.timeout, vif.round_done}); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_round();
    test_glitch_timeout();
    test_all_vote();
    test_single_held();
    test_vote_at_expiry();
    test_start_restart();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
